// File: rtl/bht_access_ctrl_if.sv
// Bundle of all non-clock/reset signals of bht_access_ctrl.
//   slave  : view taken by the controller (drives lk_ready, pred_*, upd_ready, busy,
//            mispredict*, bht_en/we/clr/addr/taken; samples the requests and bht_rd).
//   master : view taken by IF/EX control and the BHT array (drives the requests and bht_rd).
interface bht_access_ctrl_if #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned MCNT_W = 16
);
  // Fetch-stage lookup
  logic              lk_valid;
  logic [IDX_W-1:0]  lk_idx;
  logic              lk_ready;
  logic              pred_valid;
  logic              pred_taken;
  // Execute-stage update
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic              upd_pred;
  logic              upd_ready;
  // Control / status
  logic              clr_req;
  logic              busy;
  logic              mispredict;
  logic [MCNT_W-1:0] mispredict_cnt;
  // BHT access port
  logic              bht_en;
  logic              bht_we;
  logic              bht_clr;
  logic [IDX_W-1:0]  bht_addr;
  logic              bht_taken;
  logic              bht_rd;

  modport slave (
    input  lk_valid, lk_idx, upd_valid, upd_idx, upd_taken, upd_pred, clr_req, bht_rd,
    output lk_ready, pred_valid, pred_taken, upd_ready, busy, mispredict, mispredict_cnt,
    output bht_en, bht_we, bht_clr, bht_addr, bht_taken
  );

  modport master (
    output lk_valid, lk_idx, upd_valid, upd_idx, upd_taken, upd_pred, clr_req, bht_rd,
    input  lk_ready, pred_valid, pred_taken, upd_ready, busy, mispredict, mispredict_cnt,
    input  bht_en, bht_we, bht_clr, bht_addr, bht_taken
  );
endinterface

// File: rtl/bht_access_ctrl.sv
// bht_access_ctrl: sequencer/arbiter for the single-port 2-bit-counter branch history table.
// Shares the BHT port between fetch lookups and execute updates, buffers updates in a small
// FIFO with an age-based anti-starvation rule, clears the whole table after reset or on
// clr_req, and tracks mispredicts.
// Ports:
//   clk    - clock, rising edge
//   arst_n - asynchronous active-low reset
//   bus    - bht_access_ctrl_if.slave: lookup request/prediction, update request,
//            clear request, busy/mispredict status and the BHT access port
module bht_access_ctrl #(
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned ENTRIES = 2 ** IDX_W,
  parameter int unsigned QDEPTH  = 2,
  parameter int unsigned AGE_MAX = 3,
  parameter int unsigned MCNT_W  = 16
) (
  input logic             clk,
  input logic             arst_n,
  bht_access_ctrl_if.slave bus
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam int unsigned AgeW = $clog2(AGE_MAX + 1);

  localparam logic [1:0] StInit  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StClear = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [IDX_W-1:0]             clr_ptr_q, clr_ptr_d;
  logic [CntW-1:0]              count_q, count_d;
  logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [QDEPTH-1:0][IDX_W-1:0] q_idx_q, q_idx_d;
  logic [QDEPTH-1:0]            q_taken_q, q_taken_d;
  logic [AgeW-1:0]              head_age_q, head_age_d;
  logic                         pred_valid_q, pred_valid_d;
  logic                         pred_taken_q, pred_taken_d;
  logic                         mispredict_q, mispredict_d;
  logic [MCNT_W-1:0]            mcnt_q, mcnt_d;

  logic run, full, not_empty, aged;
  logic lk_ready, upd_ready, lk_grant, upd_grant, enq, deq, flush;

  // Arbitration: the update takes the port when the queue is full, the head has waited too
  // long, or nobody wants a lookup. lk_ready is deliberately independent of lk_valid.
  always_comb begin
    run       = (state_q == StRun);
    full      = (count_q == CntW'(QDEPTH));
    not_empty = (count_q != '0);
    aged      = (head_age_q >= AgeW'(AGE_MAX));
    lk_ready  = run && !(full || aged);
    upd_ready = run && !full;
    upd_grant = run && not_empty && (full || aged || !bus.lk_valid);
    lk_grant  = bus.lk_valid && lk_ready;
    enq       = bus.upd_valid && upd_ready;
    deq       = upd_grant;
    flush     = run && bus.clr_req;
  end

  // Table sequencing: INIT and CLEAR both sweep every entry, then hand over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StInit, StClear: begin
        if (clr_ptr_q == IDX_W'(ENTRIES - 1)) begin
          clr_ptr_d = '0;
          state_d   = StRun;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      StRun: begin
        if (bus.clr_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = StInit;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Update FIFO. A flush wins over any same-cycle enqueue, so nothing accepted alongside a
  // clear request ever reaches the table.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_idx_d    = q_idx_q;
    q_taken_d  = q_taken_q;
    head_age_d = head_age_q;

    if (enq) begin
      q_idx_d[wr_ptr_q]   = bus.upd_idx;
      q_taken_d[wr_ptr_q] = bus.upd_taken;
      wr_ptr_d = (wr_ptr_q == PtrW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (!enq && deq) begin
      count_d = count_q - 1'b1;
    end

    // Age belongs to the current head; any new head (after dequeue or into an empty queue)
    // starts at zero.
    if (deq || !not_empty) begin
      head_age_d = '0;
    end else if (!aged) begin
      head_age_d = head_age_q + 1'b1;
    end

    if (flush) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      head_age_d = '0;
    end
  end

  // Prediction capture and mispredict statistics.
  always_comb begin
    pred_valid_d = lk_grant;
    pred_taken_d = lk_grant ? bus.bht_rd : pred_taken_q;
    mispredict_d = enq && (bus.upd_taken != bus.upd_pred);
    mcnt_d       = mcnt_q;
    if (mispredict_d && (mcnt_q != '1)) begin
      mcnt_d = mcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= StInit;
      clr_ptr_q    <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      q_idx_q      <= '0;
      q_taken_q    <= '0;
      head_age_q   <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      q_idx_q      <= q_idx_d;
      q_taken_q    <= q_taken_d;
      head_age_q   <= head_age_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      mispredict_q <= mispredict_d;
      mcnt_q       <= mcnt_d;
    end
  end

  // BHT port mux.
  always_comb begin
    bus.bht_en    = 1'b0;
    bus.bht_we    = 1'b0;
    bus.bht_clr   = 1'b0;
    bus.bht_addr  = '0;
    bus.bht_taken = 1'b0;
    if (!run) begin
      bus.bht_en   = 1'b1;
      bus.bht_we   = 1'b1;
      bus.bht_clr  = 1'b1;
      bus.bht_addr = clr_ptr_q;
    end else if (upd_grant) begin
      bus.bht_en    = 1'b1;
      bus.bht_we    = 1'b1;
      bus.bht_addr  = q_idx_q[rd_ptr_q];
      bus.bht_taken = q_taken_q[rd_ptr_q];
    end else if (lk_grant) begin
      bus.bht_en   = 1'b1;
      bus.bht_addr = bus.lk_idx;
    end
  end

  assign bus.lk_ready       = lk_ready;
  assign bus.upd_ready      = upd_ready;
  assign bus.busy           = !run;
  assign bus.pred_valid     = pred_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_bht_access_ctrl.sv
// Directed testbench for bht_access_ctrl. Inputs change and outputs are sampled around the
// falling clock edge; BHT writes are logged on the rising edge.
module tb_bht_access_ctrl;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned MCNT_W = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  bht_access_ctrl_if #(.IDX_W(IDX_W), .MCNT_W(MCNT_W)) bus ();

  bht_access_ctrl #(
    .IDX_W  (IDX_W),
    .ENTRIES(32),
    .QDEPTH (2),
    .AGE_MAX(3),
    .MCNT_W (MCNT_W)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Write log: clear writes counted, counter-update writes recorded in order.
  int               clr_writes = 0;
  logic [IDX_W-1:0] wr_addr[$];
  logic             wr_taken[$];
  always @(posedge clk) begin
    if (arst_n && bus.bht_en && bus.bht_we) begin
      if (bus.bht_clr) begin
        clr_writes <= clr_writes + 1;
      end else begin
        wr_addr.push_back(bus.bht_addr);
        wr_taken.push_back(bus.bht_taken);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0;
    int c0;
    int pulses;
    int drops;
    logic init_ok;

    bus.lk_valid  = 1'b0;
    bus.lk_idx    = '0;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_taken = 1'b0;
    bus.upd_pred  = 1'b0;
    bus.clr_req   = 1'b0;
    bus.bht_rd    = 1'b0;

    // ---------------- reset values
    @(negedge clk);
    check("rst_outs", {bus.busy, bus.lk_ready, bus.upd_ready, bus.pred_valid, bus.pred_taken,
                       bus.mispredict, bus.bht_en, bus.bht_we, bus.bht_clr, bus.bht_taken},
          10'b1000001110);
    check("rst_addr", bus.bht_addr, 0);
    check("rst_mcnt", bus.mispredict_cnt, 0);

    // ---------------- INIT sweep: 32 clear writes, addr 0..31
    arst_n = 1'b1;
    c0 = clr_writes;
    init_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("init_addr", bus.bht_addr, i);
      if (!(bus.busy && bus.bht_en && bus.bht_we && bus.bht_clr && !bus.lk_ready
            && !bus.upd_ready)) init_ok = 1'b0;
      @(negedge clk);
    end
    #1;
    check("init_ctrl", init_ok, 1'b1);
    check("init_done", {bus.busy, bus.lk_ready, bus.upd_ready}, 3'b011);
    check("init_writes", clr_writes - c0, 32);
    check("idle_en", bus.bht_en, 1'b0);

    // ---------------- lookup idx 7, bht_rd=1
    w0 = wr_addr.size();
    bus.lk_valid = 1'b1;
    bus.lk_idx   = 5'd7;
    bus.bht_rd   = 1'b1;
    #1;
    check("lk_grant", {bus.lk_ready, bus.bht_en, bus.bht_we, bus.bht_clr}, 4'b1100);
    check("lk_addr", bus.bht_addr, 7);
    @(negedge clk);
    bus.lk_valid = 1'b0;
    bus.bht_rd   = 1'b0;
    #1;
    check("lk_pred1", {bus.pred_valid, bus.pred_taken}, 2'b11);
    @(negedge clk);
    #1;
    check("lk_pulse", bus.pred_valid, 1'b0);
    // lookup idx 20, bht_rd=0
    bus.lk_valid = 1'b1;
    bus.lk_idx   = 5'd20;
    @(negedge clk);
    bus.lk_valid = 1'b0;
    #1;
    check("lk_pred0", {bus.pred_valid, bus.pred_taken}, 2'b10);
    check("lk_nowrite", wr_addr.size() - w0, 0);

    // ---------------- continuous lookups + one update: aged head preempts on the 4th cycle
    @(negedge clk);
    w0 = wr_addr.size();
    bus.lk_valid  = 1'b1;
    bus.lk_idx    = 5'd10;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 5'd3;
    bus.upd_taken = 1'b1;
    bus.upd_pred  = 1'b1;
    #1;
    check("age_enq_ready", {bus.upd_ready, bus.lk_ready, bus.bht_we}, 3'b110);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("age_lookup", {bus.lk_ready, bus.bht_en, bus.bht_we}, 3'b110);
      @(negedge clk);
    end
    #1;
    check("age_upd", {bus.lk_ready, bus.bht_en, bus.bht_we, bus.bht_clr, bus.bht_taken},
          5'b01101);
    check("age_upd_addr", bus.bht_addr, 3);
    @(negedge clk);
    #1;
    check("age_after", bus.lk_ready, 1'b1);
    check("age_log", {wr_addr.size() - w0, 32'(wr_addr[w0]), 32'(wr_taken[w0])},
          {32'd1, 32'd3, 32'd1});

    // ---------------- three back-to-back updates under lk_valid=1
    w0 = wr_addr.size();
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 5'd11;
    bus.upd_taken = 1'b0;
    bus.upd_pred  = 1'b0;
    #1;
    check("q_rdy0", bus.upd_ready, 1'b1);
    @(negedge clk);
    bus.upd_idx   = 5'd12;
    bus.upd_taken = 1'b1;
    bus.upd_pred  = 1'b1;
    #1;
    check("q_rdy1", {bus.upd_ready, bus.lk_ready}, 2'b11);
    @(negedge clk);
    bus.upd_idx   = 5'd13;
    bus.upd_taken = 1'b0;
    bus.upd_pred  = 1'b0;
    #1;
    check("q_full", {bus.upd_ready, bus.lk_ready, bus.bht_we}, 3'b001);
    check("q_full_addr", bus.bht_addr, 11);
    @(negedge clk);
    #1;
    check("q_rdy2", {bus.upd_ready, bus.lk_ready}, 2'b11);
    @(negedge clk);
    bus.upd_valid = 1'b0;
    #1;
    check("q_full2_addr", {bus.bht_we, bus.bht_addr}, {1'b1, 5'd12});
    @(negedge clk);
    bus.lk_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("q_count", wr_addr.size() - w0, 3);
    check("q_order0", {wr_addr[w0], wr_taken[w0]}, {5'd11, 1'b0});
    check("q_order1", {wr_addr[w0+1], wr_taken[w0+1]}, {5'd12, 1'b1});
    check("q_order2", {wr_addr[w0+2], wr_taken[w0+2]}, {5'd13, 1'b0});
    check("q_mcnt", bus.mispredict_cnt, 0);

    // ---------------- 65536 mispredicting updates: counter saturates at 0xFFFF
    pulses = 0;
    drops  = 0;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 5'd5;
    bus.upd_taken = 1'b1;
    bus.upd_pred  = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      if (!bus.upd_ready) drops++;
      @(negedge clk);
      if (bus.mispredict) pulses++;
    end
    bus.upd_valid = 1'b0;
    check("mp_pulses", pulses, 65536);
    check("mp_ready", drops, 0);
    check("mp_sat", bus.mispredict_cnt, 16'hFFFF);
    @(negedge clk);
    check("mp_idle", bus.mispredict, 1'b0);
    bus.upd_valid = 1'b1;
    bus.upd_pred  = 1'b1;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    check("mp_match", {bus.mispredict, bus.mispredict_cnt}, {1'b0, 16'hFFFF});
    bus.upd_valid = 1'b1;
    bus.upd_pred  = 1'b0;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    check("mp_sat_hold", {bus.mispredict, bus.mispredict_cnt}, {1'b1, 16'hFFFF});
    repeat (3) @(negedge clk);

    // ---------------- clr_req with queued updates: they are dropped, 32 clears follow
    w0 = wr_addr.size();
    c0 = clr_writes;
    bus.lk_valid  = 1'b1;
    bus.lk_idx    = 5'd9;
    bus.bht_rd    = 1'b1;
    bus.upd_valid = 1'b1;
    bus.upd_idx   = 5'd21;
    bus.upd_taken = 1'b1;
    bus.upd_pred  = 1'b1;
    @(negedge clk);
    bus.upd_idx   = 5'd22;
    bus.upd_taken = 1'b0;
    bus.upd_pred  = 1'b0;
    bus.clr_req   = 1'b1;
    #1;
    check("clr_pre", {bus.upd_ready, bus.lk_ready, bus.bht_we}, 3'b110);
    @(negedge clk);
    bus.clr_req   = 1'b0;
    bus.upd_valid = 1'b0;
    bus.lk_valid  = 1'b0;
    bus.bht_rd    = 1'b0;
    #1;
    check("clr_enter", {bus.busy, bus.lk_ready, bus.upd_ready, bus.pred_valid, bus.pred_taken},
          5'b10011);
    for (int i = 0; i < 32; i++) begin
      check("clr_addr", bus.bht_addr, i);
      bus.clr_req = (i == 10);
      @(negedge clk);
      #1;
    end
    bus.clr_req = 1'b0;
    check("clr_done", {bus.busy, bus.lk_ready, bus.upd_ready}, 3'b011);
    check("clr_writes", clr_writes - c0, 32);
    check("clr_dropped", wr_addr.size() - w0, 0);
    check("clr_mcnt", bus.mispredict_cnt, 16'hFFFF);

    // ---------------- reset in the middle of CLEAR restarts INIT at 0
    bus.clr_req = 1'b1;
    @(negedge clk);
    #1;
    bus.clr_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("mid_addr", bus.bht_addr, 5);
    arst_n = 1'b0;
    #1;
    check("mid_rst", {bus.busy, bus.bht_clr, 27'(bus.bht_addr), bus.mispredict_cnt},
          {1'b1, 1'b1, 27'd0, 16'd0});
    @(negedge clk);
    arst_n = 1'b1;
    c0 = clr_writes;
    #1;
    check("reinit_addr0", bus.bht_addr, 0);
    repeat (32) @(negedge clk);
    #1;
    check("reinit_done", {bus.busy, bus.lk_ready, bus.upd_ready}, 3'b011);
    check("reinit_writes", clr_writes - c0, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bht_access_ctrl.md
# bht_access_ctrl

Sequencer and arbiter for the 32-entry, 2-bit-counter branch history table (BHT). The table has a single access port; this block shares it between the fetch-stage prediction lookup and the execute-stage outcome update, buffers updates in a 2-entry queue, and clears every entry after reset or on request. It sits between IF/EX control and the BHT, and also produces the mispredict pulse and a mispredict statistics counter.

## Interface
- IDX_W, 5, BHT index width (PC low bits).
- ENTRIES, 32, number of BHT entries (2**IDX_W).
- QDEPTH, 2, update queue depth.
- AGE_MAX, 3, queue-head wait limit before an update preempts lookups.
- MCNT_W, 16, mispredict counter width.

- clk  in  1  single clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- lk_valid  in  1  fetch requests a prediction.
- lk_idx  in  IDX_W  lookup index.
- lk_ready  out  1  lookup accepted this cycle when high together with lk_valid.
- pred_valid  out  1  prediction available, one-cycle pulse.
- pred_taken  out  1  predicted direction.
- upd_valid  in  1  EX reports a resolved branch.
- upd_idx  in  IDX_W  index of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_pred  in  1  direction that was predicted.
- upd_ready  out  1  update queue can accept.
- clr_req  in  1  request a full table clear, pulse.
- busy  out  1  high in INIT or CLEAR.
- mispredict  out  1  one-cycle pulse on an accepted update with upd_taken != upd_pred.
- mispredict_cnt  out  MCNT_W  saturating mispredict count.
- bht_en  out  1  BHT port access this cycle.
- bht_we  out  1  1 = counter update, 0 = read.
- bht_clr  out  1  force the addressed entry to 2'b00.
- bht_addr  out  IDX_W  BHT port address.
- bht_taken  out  1  outcome applied on an update write.
- bht_rd  in  1  BHT prediction bit for bht_addr, combinational.

## Operation
- States: INIT, RUN, CLEAR. Reset enters INIT with clr_ptr=0.
- INIT/CLEAR: each cycle drive bht_en=1, bht_we=1, bht_clr=1, bht_addr=clr_ptr; increment clr_ptr. After writing ENTRIES-1, clr_ptr wraps to 0 and the state goes to RUN. In these states lk_ready=0, upd_ready=0 and busy=1.
- RUN, grant per cycle: the update wins if the queue count==QDEPTH, or the head age>=AGE_MAX, or (count>0 and !lk_valid). Otherwise the lookup wins.
- lk_ready = RUN && !(count==QDEPTH || head_age>=AGE_MAX). It does not depend on lk_valid.
- Lookup grant: bht_en=1, bht_we=0, bht_addr=lk_idx. bht_rd is registered into pred_taken, and pred_valid=1 in the next cycle.
- Update grant: bht_en=1, bht_we=1, bht_clr=0, bht_addr/bht_taken from the queue head, then dequeue. Head age resets to 0 on dequeue. The age increments each cycle the head waits, saturating at AGE_MAX.
- Queue: FIFO with 2-entry circular buffer and wrap-around pointers. upd_ready = RUN && count<QDEPTH, computed from the registered count. An enqueue and a dequeue in the same cycle leave the count unchanged. A new head starts at age 0.
- Mispredicts are evaluated at enqueue: mispredict pulses the next cycle, and mispredict_cnt increments, saturating at all-ones.
- clr_req in RUN:
  - the queue is flushed (pending updates are dropped) and any same-cycle lookup or update grant completes normally;
  - the next state is CLEAR, starting at clr_ptr=0.
- clr_req in INIT or CLEAR is ignored.
- mispredict_cnt is cleared only by reset.
- Known hazard: a lookup to an index with a queued, unwritten update reads the old counter. No forwarding is done.
- Reset mid-operation: all state is reset immediately, the queue is emptied, and INIT restarts from index 0.

## Timing
- Reset values:
  - state=INIT, clr_ptr=0, count=0;
  - lk_ready=0, upd_ready=0, pred_valid=0, pred_taken=0, mispredict=0, mispredict_cnt=0, busy=1;
  - bht_en=1, bht_we=1, bht_clr=1, bht_addr=0, bht_taken=0.
- After deassertion, the clear writes occur at edges 1..32 (addr 0..31). RUN, lk_ready=1 and upd_ready=1 hold in the cycle after edge 32.
- Lookup latency is 1 cycle: accepted at edge N, pred_valid/pred_taken valid between edges N and N+1.
- Update write latency is at least 1 cycle after enqueue. It is at most AGE_MAX+1 cycles after reaching the head under continuous lookups.
- A CLEAR sequence takes exactly ENTRIES cycles. busy falls in the same cycle that lk_ready rises.

## Test plan
- Reset, then idle → busy=1 for 32 cycles with bht_addr stepping 0..31 (bht_clr=1); lk_ready=1 on cycle 33.
- Lookup idx=7 with bht_rd=1 at acceptance → pred_valid=1, pred_taken=1 exactly one cycle later; no BHT write occurs.
- lk_valid held high continuously plus one update (idx=3, taken=1) → lookups are served for 3 cycles; on the 4th, lk_ready=0 and the BHT gets we=1, addr=3, taken=1.
- Three back-to-back updates while lk_valid=1 → upd_ready=0 after 2 are queued; the queue-full grant drains idx in FIFO order and no update is lost or duplicated.
- Update with upd_pred=0, upd_taken=1, repeated 65536 times → a mispredict pulse each time and mispredict_cnt saturates at 0xFFFF. An update with matching prediction produces no pulse.
- clr_req with 2 queued updates → the queued updates are never written; 32 clear writes follow; mispredict_cnt is unchanged. arst_n asserted mid-CLEAR → INIT restarts at addr 0.
